// File: rtl/freq_spectrum_buffer.sv
// Ping-pong capture buffer for the positive-frequency half of each FFT power frame.
// Publishes completed frames to a registered read port with per-frame peak tracking.
module freq_spectrum_buffer #(
  parameter int unsigned NBINS = 512
) (
  input  logic       ckFreq,
  input  logic       btnL,
  input  logic       flgFreqSampleValid,
  input  logic [9:0] addrFreq,
  input  logic [7:0] byteFreqSample,
  input  logic       flgFreeze,
  input  logic       rdEn,
  input  logic [8:0] rdAddr,
  output logic [7:0] rdData,
  output logic       rdValid,
  output logic       flgBufValid,
  output logic       flgFrameReady,
  output logic       flgSyncErr,
  output logic [8:0] peakBin,
  output logic [7:0] peakMag,
  output logic [15:0] cntFrames
);

  localparam int unsigned AW   = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam logic [9:0]  LAST = 10'(NBINS - 1);

  typedef enum logic [2:0] {
    ST_SYNC    = 3'b001,
    ST_CAPTURE = 3'b010,
    ST_PUBLISH = 3'b100
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] exp_addr, exp_nxt;
  logic [8:0] run_bin, run_bin_nxt;
  logic [7:0] run_mag, run_mag_nxt;
  logic       bank_wr;
  logic       wr_en, err_nxt, publish;

  logic [7:0] mem [2][NBINS];

  always_comb begin
    state_nxt   = state;
    exp_nxt     = exp_addr;
    run_bin_nxt = run_bin;
    run_mag_nxt = run_mag;
    wr_en       = 1'b0;
    err_nxt     = 1'b0;
    publish     = 1'b0;
    unique case (state)
      ST_SYNC: begin
        if (flgFreqSampleValid && addrFreq == '0) begin
          wr_en       = 1'b1;
          exp_nxt     = 10'd1;
          run_bin_nxt = '0;
          run_mag_nxt = '0;
          state_nxt   = (NBINS == 1) ? ST_PUBLISH : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (flgFreqSampleValid) begin
          if (addrFreq == exp_addr) begin
            // exp_addr is never 0 here, so DC cannot win the peak
            wr_en   = 1'b1;
            exp_nxt = exp_addr + 10'd1;
            if (byteFreqSample > run_mag) begin
              run_bin_nxt = addrFreq[8:0];
              run_mag_nxt = byteFreqSample;
            end
            if (addrFreq == LAST) state_nxt = ST_PUBLISH;
          end else begin
            err_nxt = 1'b1;
            if (addrFreq == '0) begin
              wr_en       = 1'b1;
              exp_nxt     = 10'd1;
              run_bin_nxt = '0;
              run_mag_nxt = '0;
            end else begin
              state_nxt = ST_SYNC;
            end
          end
        end
      end
      ST_PUBLISH: begin
        publish   = 1'b1;
        state_nxt = ST_SYNC;
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge ckFreq) begin
    if (wr_en && !btnL) mem[bank_wr][addrFreq[AW-1:0]] <= byteFreqSample;
  end

  always_ff @(posedge ckFreq) begin
    if (btnL) begin
      state         <= ST_SYNC;
      exp_addr      <= '0;
      run_bin       <= '0;
      run_mag       <= '0;
      bank_wr       <= 1'b0;
      rdData        <= '0;
      rdValid       <= 1'b0;
      flgBufValid   <= 1'b0;
      flgFrameReady <= 1'b0;
      flgSyncErr    <= 1'b0;
      peakBin       <= '0;
      peakMag       <= '0;
      cntFrames     <= '0;
    end else begin
      state         <= state_nxt;
      exp_addr      <= exp_nxt;
      run_bin       <= run_bin_nxt;
      run_mag       <= run_mag_nxt;
      flgSyncErr    <= err_nxt;
      flgFrameReady <= 1'b0;
      if (publish && !flgFreeze) begin
        bank_wr       <= ~bank_wr;
        peakBin       <= run_bin;
        peakMag       <= run_mag;
        flgFrameReady <= 1'b1;
        flgBufValid   <= 1'b1;
        cntFrames     <= cntFrames + 16'd1;
      end
      // read uses the pre-swap bank, so a read on the swap edge returns old data
      rdValid <= rdEn;
      if (rdEn) rdData <= flgBufValid ? mem[~bank_wr][rdAddr[AW-1:0]] : '0;
    end
  end

endmodule
